// File: rtl/fpadd_pipe.sv
// fpadd_pipe: pipelined IEEE-754 adder/subtractor with round-to-nearest-even.
// An input capture register is followed by four stages: unpack, align/add,
// normalise, round/pack. A pair captured at edge k leaves the output register
// at edge k+4. A stall freezes every register, and reset (active low) clears all
// of them.
module fpadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic [1:0]               op,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  // Extended mantissa: hidden bit, fraction, guard, round, sticky
  localparam int MX   = MAN_W + 4;
  localparam int LZ_W = $clog2(MX + 1);
  // Signed working exponent, wide enough for carry-up and leading-zero shifts
  localparam int EE   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic signed [EE-1:0] EXP_ONES = EE'((1 << EXP_W) - 1);
  localparam logic signed [EE-1:0] EXP_ONE  = EE'(1);

  // Special-case class carried alongside the datapath
  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  // ---------------- input capture ----------------
  logic             in_valid_reg;
  logic [1:0]       op_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;

  // Register the incoming operand pair; a stalled cycle drops the new pair
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_valid_reg <= 1'b0;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
    end else if (!stall) begin
      in_valid_reg <= in_valid;
      op_reg       <= op;
      a_reg        <= a;
      b_reg        <= b;
    end
  end

  // ---------------- stage 1: unpack / classify / swap ----------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b, frac_af, frac_bf;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, swap;

  logic             s1_sign_l_next, s1_sign_s_next, s1_spec_sign_next;
  logic [EXP_W-1:0] s1_exp_next, s1_diff_next;
  logic [MAN_W:0]   s1_man_l_next, s1_man_s_next;
  logic [1:0]       s1_spec_next;

  logic             s1_valid_reg, s1_sign_l_reg, s1_sign_s_reg, s1_spec_sign_reg;
  logic [EXP_W-1:0] s1_exp_reg, s1_diff_reg;
  logic [MAN_W:0]   s1_man_l_reg, s1_man_s_reg;
  logic [1:0]       s1_spec_reg;

  // Split fields, flush zero-exponent inputs, classify, order by magnitude
  always_comb begin
    sign_a  = a_reg[W-1];
    sign_b  = b_reg[W-1] ^ (op_reg == 2'b01);
    exp_a   = a_reg[W-2:MAN_W];
    exp_b   = b_reg[W-2:MAN_W];
    frac_a  = a_reg[MAN_W-1:0];
    frac_b  = b_reg[MAN_W-1:0];
    zero_a  = (exp_a == '0);
    zero_b  = (exp_b == '0);
    inf_a   = (exp_a == '1) && (frac_a == '0);
    inf_b   = (exp_b == '1) && (frac_b == '0);
    nan_a   = (exp_a == '1) && (frac_a != '0);
    nan_b   = (exp_b == '1) && (frac_b != '0);
    frac_af = zero_a ? '0 : frac_a;
    frac_bf = zero_b ? '0 : frac_b;
    swap    = {exp_b, frac_bf} > {exp_a, frac_af};

    if (swap) begin
      s1_sign_l_next = sign_b;
      s1_sign_s_next = sign_a;
      s1_exp_next    = exp_b;
      s1_diff_next   = exp_b - exp_a;
      s1_man_l_next  = {~zero_b, frac_bf};
      s1_man_s_next  = {~zero_a, frac_af};
    end else begin
      s1_sign_l_next = sign_a;
      s1_sign_s_next = sign_b;
      s1_exp_next    = exp_a;
      s1_diff_next   = exp_a - exp_b;
      s1_man_l_next  = {~zero_a, frac_af};
      s1_man_s_next  = {~zero_b, frac_bf};
    end

    s1_spec_next      = SP_NONE;
    s1_spec_sign_next = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      s1_spec_next = SP_NAN;
    end else if (inf_a) begin
      s1_spec_next      = SP_INF;
      s1_spec_sign_next = sign_a;
    end else if (inf_b) begin
      s1_spec_next      = SP_INF;
      s1_spec_sign_next = sign_b;
    end else if (zero_a && zero_b) begin
      // Only (-0)+(-0) keeps a negative sign
      s1_spec_next      = SP_ZERO;
      s1_spec_sign_next = sign_a & sign_b;
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_reg     <= 1'b0;
      s1_sign_l_reg    <= 1'b0;
      s1_sign_s_reg    <= 1'b0;
      s1_spec_sign_reg <= 1'b0;
      s1_exp_reg       <= '0;
      s1_diff_reg      <= '0;
      s1_man_l_reg     <= '0;
      s1_man_s_reg     <= '0;
      s1_spec_reg      <= SP_NONE;
    end else if (!stall) begin
      s1_valid_reg     <= in_valid_reg;
      s1_sign_l_reg    <= s1_sign_l_next;
      s1_sign_s_reg    <= s1_sign_s_next;
      s1_spec_sign_reg <= s1_spec_sign_next;
      s1_exp_reg       <= s1_exp_next;
      s1_diff_reg      <= s1_diff_next;
      s1_man_l_reg     <= s1_man_l_next;
      s1_man_s_reg     <= s1_man_s_next;
      s1_spec_reg      <= s1_spec_next;
    end
  end

  // ---------------- stage 2: align / add ----------------
  logic [31:0]      diff_ext;
  logic [MX-1:0]    a_ext, b_ext, b_shift, lost_mask, b_al;
  logic             eff_sub;
  logic [MX:0]      sum_next;

  logic             s2_valid_reg, s2_sign_reg, s2_spec_sign_reg;
  logic [EXP_W-1:0] s2_exp_reg;
  logic [MX:0]      s2_sum_reg;
  logic [1:0]       s2_spec_reg;

  // Shift the smaller mantissa right with sticky collection, then add/subtract
  always_comb begin
    diff_ext  = 32'(s1_diff_reg);
    a_ext     = {s1_man_l_reg, 3'b000};
    b_ext     = {s1_man_s_reg, 3'b000};
    b_shift   = b_ext >> s1_diff_reg;
    lost_mask = ~({MX{1'b1}} << s1_diff_reg);
    if (diff_ext >= 32'(MAN_W + 3)) begin
      b_al = {{(MX-1){1'b0}}, |s1_man_s_reg};
    end else begin
      b_al = {b_shift[MX-1:1], b_shift[0] | (|(b_ext & lost_mask))};
    end
    eff_sub = s1_sign_l_reg ^ s1_sign_s_reg;
    // The larger magnitude is always A, so the difference never goes negative
    if (eff_sub) begin
      sum_next = {1'b0, a_ext} - {1'b0, b_al};
    end else begin
      sum_next = {1'b0, a_ext} + {1'b0, b_al};
    end
  end

  // Stage 2 register
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid_reg     <= 1'b0;
      s2_sign_reg      <= 1'b0;
      s2_spec_sign_reg <= 1'b0;
      s2_exp_reg       <= '0;
      s2_sum_reg       <= '0;
      s2_spec_reg      <= SP_NONE;
    end else if (!stall) begin
      s2_valid_reg     <= s1_valid_reg;
      s2_sign_reg      <= s1_sign_l_reg;
      s2_spec_sign_reg <= s1_spec_sign_reg;
      s2_exp_reg       <= s1_exp_reg;
      s2_sum_reg       <= sum_next;
      s2_spec_reg      <= s1_spec_reg;
    end
  end

  // ---------------- stage 3: normalise ----------------
  logic [LZ_W-1:0]  lz;
  logic             lz_found;
  logic [MX-1:0]    norm_next;
  logic [EE-1:0]    exp_base;
  logic signed [EE-1:0] norm_exp_next;

  logic             s3_valid_reg, s3_sign_reg, s3_spec_sign_reg, s3_zero_reg;
  logic signed [EE-1:0] s3_exp_reg;
  logic [MX-1:0]    s3_man_reg;
  logic [1:0]       s3_spec_reg;

  // Carry-out shifts right by one; otherwise count leading zeros and shift left
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = MX - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s2_sum_reg[i]) begin
          lz_found = 1'b1;
        end else begin
          lz = lz + LZ_W'(1);
        end
      end
    end
    exp_base = EE'(s2_exp_reg);
    if (s2_sum_reg[MX]) begin
      norm_next     = {s2_sum_reg[MX:2], s2_sum_reg[1] | s2_sum_reg[0]};
      norm_exp_next = exp_base + EE'(1);
    end else begin
      norm_next     = s2_sum_reg[MX-1:0] << lz;
      norm_exp_next = exp_base - EE'(lz);
    end
  end

  // Stage 3 register
  always_ff @(posedge clk) begin
    if (!reset) begin
      s3_valid_reg     <= 1'b0;
      s3_sign_reg      <= 1'b0;
      s3_spec_sign_reg <= 1'b0;
      s3_zero_reg      <= 1'b0;
      s3_exp_reg       <= '0;
      s3_man_reg       <= '0;
      s3_spec_reg      <= SP_NONE;
    end else if (!stall) begin
      s3_valid_reg     <= s2_valid_reg;
      s3_sign_reg      <= s2_sign_reg;
      s3_spec_sign_reg <= s2_spec_sign_reg;
      s3_zero_reg      <= (s2_sum_reg == '0);
      s3_exp_reg       <= norm_exp_next;
      s3_man_reg       <= norm_next;
      s3_spec_reg      <= s2_spec_reg;
    end
  end

  // ---------------- stage 4: round / pack ----------------
  logic                 rnd_inc, rnd_carry, inexact;
  logic [MAN_W+1:0]     rounded;
  logic signed [EE-1:0] exp_r;
  logic [MAN_W-1:0]     frac_r;
  logic [W-1:0]         result_next;
  logic [3:0]           flags_next;

  logic                 out_valid_reg;
  logic [W-1:0]         result_reg;
  logic [3:0]           flags_reg;

  // Round to nearest even, detect overflow/underflow, then apply special cases
  always_comb begin
    inexact   = |s3_man_reg[2:0];
    rnd_inc   = s3_man_reg[2] & (s3_man_reg[1] | s3_man_reg[0] | s3_man_reg[3]);
    rounded   = {1'b0, s3_man_reg[MX-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
    rnd_carry = rounded[MAN_W+1];
    exp_r     = s3_exp_reg + EE'(rnd_carry);
    frac_r    = rnd_carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

    result_next = '0;
    flags_next  = 4'b0000;
    case (s3_spec_reg)
      SP_NAN: begin
        result_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_next  = 4'b0011;
      end
      SP_INF: begin
        result_next = {s3_spec_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_next  = {s3_spec_sign_reg, 3'b000};
      end
      SP_ZERO: begin
        result_next = {s3_spec_sign_reg, {(W-1){1'b0}}};
        flags_next  = {s3_spec_sign_reg, 3'b100};
      end
      default: begin
        if (s3_zero_reg) begin
          // Exact cancellation of nonzero operands is +0
          result_next = '0;
          flags_next  = 4'b0100;
        end else if (exp_r >= EXP_ONES) begin
          result_next = {s3_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_next  = {s3_sign_reg, 3'b011};
        end else if (exp_r < EXP_ONE) begin
          result_next = {s3_sign_reg, {(W-1){1'b0}}};
          flags_next  = {s3_sign_reg, 3'b110};
        end else begin
          result_next = {s3_sign_reg, exp_r[EXP_W-1:0], frac_r};
          flags_next  = {s3_sign_reg, 1'b0, inexact, 1'b0};
        end
      end
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else if (!stall) begin
      out_valid_reg <= s3_valid_reg;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule

// File: doc/fpadd_pipe.md
# fpadd_pipe

Pipelined, parametrised IEEE-754 floating-point adder/subtractor for the processor's FP datapath. Accepts one operand pair per cycle under a valid/stall handshake and returns a correctly rounded (round-to-nearest-even) sum or difference after a fixed 4-stage latency, with NZCV flags. Adds what the single-cycle FP ALU lacks:

- exponent and mantissa widths set by parameter
- subtraction opcode
- leading-zero normalisation
- guard/round/sticky rounding
- special-value handling
- pipelining

## Interface
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width (hidden bit not counted). Word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk).
- in_valid  in  1  operand pair present this cycle.
- stall  in  1  1 = every pipeline register holds; inputs ignored.
- op  in  2  00 add, 01 subtract (a−b); 10/11 treated as add.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result/flags valid this cycle.
- result  out  W  packed IEEE result.
- flags  out  4  {N, Z, C, V}.

## Operation
- Stage 1 (unpack):
  - Split fields. For subtract, invert the sign of b.
  - Exponent 0 operands are flushed to signed zero (no subnormal inputs).
  - Classify each operand as zero/inf/NaN.
  - Swap so the operand with the larger magnitude is A; the exponent diff d is always ≥0.
- Stage 2 (align/add):
  - Mantissas carry the hidden 1 plus 3 low bits (G, R, S).
  - Shift B right by d; every bit shifted past S ORs into S. If d ≥ MAN_W+3, B becomes only S = (B≠0).
  - Same effective sign: add, with one carry bit. Otherwise: subtract (A≥B guaranteed); the result sign is A's sign.
- Stage 3 (normalise):
  - Carry out set: shift right 1 (old LSB ORs into S), exponent +1.
  - Otherwise: count leading zeros, shift left, exponent − count.
  - Zero magnitude gives exact zero.
- Stage 4 (round/pack):
  - RNE: increment when G=1 and (R|S|LSB)=1.
  - Rounding carry renormalises (exponent +1).
  - Exponent ≥ all-ones: ±inf, V=1.
  - Exponent ≤ 0: flush to signed zero.
- Specials:
  - Any NaN input, or inf + (−inf): canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0).
  - inf ± finite: that inf.
  - Exact cancellation x+(−x): +0. (−0)+(−0): −0.
- Flags:
  - N = result sign, 0 for NaN.
  - Z = result is ±0.
  - C = inexact: G|R|S nonzero before rounding, or overflow, or flush-to-zero of a nonzero value.
  - V = overflow to inf.
  - NaN result forces flags 0011 (unordered, ARM convention).

## Timing
- Latency 4: a pair sampled at edge k with in_valid=1 and stall=0 appears on result/flags with out_valid=1 after edge k+4 (absent stalls).
- Throughput one pair per cycle. Each valid bit travels with its stage data.
- in_valid=0 inserts a bubble. The data registers of bubble stages may update, but out_valid stays 0 for them.
- stall=1: all valid bits and data registers hold, including the output stage. out_valid/result/flags stay constant. A pair on a/b with stall=1 is dropped.
- Reset (reset=0 at an edge): all valid bits cleared, and result, flags and all stage registers set to 0. This takes priority over stall and in_valid. Reset mid-stream discards every in-flight operation; out_valid=0 from the first edge after reset asserts until a new pair completes 4 cycles after reset releases.
- No combinational path from inputs to outputs.

## Test plan
- 3F800000 + 3F800000, op=00, single pulse: out_valid only 4 edges later, result 40000000, flags 0000. Then 40400000 − 3F800000 (op=01) gives 40000000.
- 3F800000 − 3F800000 gives 00000000, flags 0100. 80000000 + 80000000 gives 80000000, flags 1100.
- 3F800000 + 33800000 (tie) gives 3F800000, C=1. 3F800000 + 33C00000 gives 3F800001, flags 0010.
- 7F7FFFFF + 7F7FFFFF gives 7F800000, flags 0011. 7F800000 + FF800000 gives 7FC00000, flags 0011. 7FC00001 + 3F800000 gives 7FC00000.
- Stream of 8 back-to-back pairs with stall high for 2 cycles in the middle: 8 results in order, none lost or duplicated, outputs frozen during the stall.
- reset=0 for one edge while 3 ops are in flight: out_valid low for the next 4 cycles, no stale results. With EXP_W=5, MAN_W=10: 3C00 + 3C00 gives 4000.
